// File: rtl/display_refresh_scheduler_pkg.sv
// display_pkg: MAX7219 register map, scheduler state types and word builders.
package display_pkg;
  localparam logic [3:0] REG_DIGIT0    = 4'h1;
  localparam logic [3:0] REG_DECODE    = 4'h9;
  localparam logic [3:0] REG_INTENSITY = 4'hA;
  localparam logic [3:0] REG_SCANLIM   = 4'hB;
  localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
  localparam logic [3:0] REG_TEST      = 4'hF;
  localparam logic [2:0] INIT_LAST     = 3'd4;
  typedef enum logic [1:0] {INIT, IDLE, FRAME, CFG} top_state_t;
  typedef enum logic [1:0] {T_WAIT_RDY, T_SHIFT, T_GAP} txn_state_t;
  function automatic logic [15:0] make_word(input logic [3:0] addr, input logic [7:0] data);
    return {4'h0, addr, data};
  endfunction
  function automatic logic [15:0] init_word(input logic [2:0] idx, input logic [3:0] scan,
                                            input logic [3:0] inten);
    return idx == 3'd0 ? make_word(REG_SHUTDOWN, 8'h01) :
           idx == 3'd1 ? make_word(REG_DECODE, 8'hFF) :
           idx == 3'd2 ? make_word(REG_SCANLIM, {4'h0, scan}) :
           idx == 3'd3 ? make_word(REG_INTENSITY, {4'h0, inten}) :
                         make_word(REG_TEST, 8'h00);
  endfunction
endpackage

// File: rtl/display_refresh_scheduler_if.sv
// display_refresh_scheduler_if: word/CS handshake between scheduler and SPI word master.
interface display_refresh_scheduler_if;
  logic [15:0] spi_word;
  logic        spi_cs;
  logic        spi_ready;
  logic        spi_done;
  modport master (output spi_word, spi_cs, input spi_ready, spi_done);
  modport slave (input spi_word, spi_cs, output spi_ready, spi_done);
endinterface

// File: rtl/display_refresh_scheduler_txn.sv
// spi_word_txn: one word transaction - wait ready, hold CS low until done, wait ready again.
module spi_word_txn
  import display_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] word_in,
  input  logic        spi_ready,
  input  logic        spi_done,
  output logic        spi_cs,
  output logic [15:0] spi_word,
  output logic        txn_done
);
  txn_state_t  r_state, w_next;
  logic        r_cs;
  logic [15:0] r_word;
  always_ff @(posedge clk)
    if (!rst_n) r_state <= T_WAIT_RDY;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      T_WAIT_RDY: if (start && spi_ready) w_next = T_SHIFT;
      T_SHIFT:    if (spi_done) w_next = T_GAP;
      T_GAP:      if (spi_ready) w_next = T_WAIT_RDY;
      default:    w_next = T_WAIT_RDY;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_cs   <= 1'b1;
      r_word <= '0;
    end else if (r_state == T_WAIT_RDY && start && spi_ready) begin
      r_cs   <= 1'b0;
      r_word <= word_in;
    end else if (r_state == T_SHIFT && spi_done) begin
      r_cs   <= 1'b1;
    end
  always_comb begin
    spi_cs   = r_cs;
    spi_word = r_word;
    txn_done = r_state == T_GAP && spi_ready;
  end
endmodule

// File: rtl/display_refresh_scheduler.sv
// display_refresh_scheduler: init table, then 100 Hz digit frames arbitrated against
// intensity updates, all funnelled through one shared SPI word transaction engine.
module display_refresh_scheduler
  import display_pkg::*;
#(
  parameter int                    NUM_DIGITS     = 6,
  parameter logic [NUM_DIGITS-1:0] DP_MASK        = 6'b010100,
  parameter logic [3:0]            SCAN_LIMIT     = 4'd5,
  parameter logic [3:0]            INIT_INTENSITY = 4'h8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      tick,
  input  logic                      disp_ena,
  input  logic [4*NUM_DIGITS-1:0]   digits_in,
  input  logic                      int_req,
  input  logic [3:0]                int_val,
  output logic                      int_ack,
  output logic                      busy,
  output logic                      init_done,
  output logic                      overrun,
  display_refresh_scheduler_if.master spi
);
  localparam logic [2:0] LAST_DIGIT = 3'(NUM_DIGITS - 1);
  top_state_t              r_state, w_next;
  logic [2:0]              r_idx;
  logic [4*NUM_DIGITS-1:0] r_snap;
  logic [3:0]              r_int_val;
  logic                    r_pending, r_overrun, r_init_done;
  logic                    w_start, w_txn_done, w_last, w_tick_set, w_take_frame;
  logic [4:0]              w_nib_base;
  logic [15:0]             w_word;
  always_ff @(posedge clk)
    if (!rst_n) r_state <= INIT;
    else r_state <= w_next;
  always_comb begin
    w_last = r_state == INIT ? r_idx == INIT_LAST : r_state == FRAME ? r_idx == LAST_DIGIT : 1'b1;
    w_next = r_state;
    case (r_state)
      INIT, FRAME: if (w_txn_done && w_last) w_next = IDLE;
      IDLE:        w_next = int_req ? CFG : r_pending ? FRAME : IDLE;
      CFG:         if (w_txn_done) w_next = IDLE;
      default:     w_next = INIT;
    endcase
  end
  always_comb begin
    w_start    = r_state != IDLE;
    busy       = w_start;
    int_ack    = r_state == CFG && w_txn_done;
    init_done  = r_init_done;
    overrun    = r_overrun;
    w_nib_base = {r_idx, 2'b00};
    w_word     = r_state == INIT ? init_word(r_idx, SCAN_LIMIT, INIT_INTENSITY) :
                 r_state == CFG  ? make_word(REG_INTENSITY, {4'h0, r_int_val}) :
                 make_word(REG_DIGIT0 + {1'b0, r_idx},
                           {DP_MASK[r_idx], 3'b000, r_snap[w_nib_base +: 4]});
  end
  // ticks are only meaningful once the display is configured
  assign w_tick_set   = r_state != INIT && tick && disp_ena;
  assign w_take_frame = r_state == IDLE && !int_req && r_pending;
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_idx       <= '0;
      r_pending   <= 1'b0;
      r_overrun   <= 1'b0;
      r_init_done <= 1'b0;
      r_snap      <= '0;
      r_int_val   <= '0;
    end else begin
      if (w_txn_done) r_idx <= w_last ? 3'd0 : r_idx + 3'd1;
      r_pending <= (r_pending && !w_take_frame) || w_tick_set;
      if (w_tick_set && r_pending && !w_take_frame) r_overrun <= 1'b1;
      if (r_state == INIT && w_txn_done && w_last) r_init_done <= 1'b1;
      if (w_take_frame) r_snap <= digits_in;
      if (r_state == IDLE && int_req) r_int_val <= int_val;
    end
  spi_word_txn u_txn (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (w_start),
    .word_in  (w_word),
    .spi_ready(spi.spi_ready),
    .spi_done (spi.spi_done),
    .spi_cs   (spi.spi_cs),
    .spi_word (spi.spi_word),
    .txn_done (w_txn_done)
  );
endmodule

// File: tb/tb_display_refresh_scheduler.sv
// tb_display_refresh_scheduler: directed bench with a 66-cycle SPI master model.
module tb_display_refresh_scheduler;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        disp_ena = 1'b0;
  logic [23:0] digits_in = '0;
  logic        int_req = 1'b0;
  logic [3:0]  int_val = '0;
  logic        int_ack, busy, init_done, overrun;
  int          n_chk = 0;
  int          n_err = 0;
  int          ms = 0;
  int          cnt = 0;
  int          stab_err = 0;
  int          ack_cnt = 0;
  int          a0;
  logic [15:0] cap;
  logic [15:0] q[$];
  localparam logic [15:0] INIT_W [5] = '{16'h0C01, 16'h09FF, 16'h0B05, 16'h0A08, 16'h0F00};
  localparam logic [15:0] FRM_A  [6] = '{16'h0105, 16'h0204, 16'h0383, 16'h0402, 16'h0581, 16'h0600};
  localparam logic [15:0] FRM_B  [6] = '{16'h0109, 16'h0209, 16'h0389, 16'h0409, 16'h0589, 16'h0600};

  display_refresh_scheduler_if bus ();

  display_refresh_scheduler dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .disp_ena (disp_ena),
    .digits_in(digits_in),
    .int_req  (int_req),
    .int_val  (int_val),
    .int_ack  (int_ack),
    .busy     (busy),
    .init_done(init_done),
    .overrun  (overrun),
    .spi      (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) begin
      bus.spi_ready <= 1'b1;
      bus.spi_done  <= 1'b0;
      ms            <= 0;
    end else begin
      case (ms)
        0: if (!bus.spi_cs) begin
          bus.spi_ready <= 1'b0;
          cap           <= bus.spi_word;
          q.push_back(bus.spi_word);
          cnt           <= 0;
          ms            <= 1;
        end
        1: begin
          if (bus.spi_word !== cap || bus.spi_cs !== 1'b0) stab_err <= stab_err + 1;
          cnt <= cnt + 1;
          if (cnt == 65) begin
            bus.spi_done <= 1'b1;
            ms           <= 2;
          end
        end
        default: if (bus.spi_cs) begin
          bus.spi_done  <= 1'b0;
          bus.spi_ready <= 1'b1;
          ms            <= 0;
        end
      endcase
    end
  end

  always @(negedge clk) if (int_ack) ack_cnt <= ack_cnt + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic wait_quiet(input string tag, input int budget);
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < budget) begin
      @(negedge clk);
      n++;
      quiet = (!busy && ms == 0) ? quiet + 1 : 0;
    end
    chk({tag, " settle"}, 32'(n < budget), 32'd1);
  endtask

  task automatic wait_ack(input string tag, input int budget);
    int n = 0;
    while (!int_ack && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " ack seen"}, 32'(int_ack), 32'd1);
    int_req = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset cs", 32'(bus.spi_cs), 32'd1);
    chk("reset word", 32'(bus.spi_word), 32'h0);
    chk("reset int_ack", 32'(int_ack), 32'd0);
    chk("reset busy", 32'(busy), 32'd1);
    chk("reset init_done", 32'(init_done), 32'd0);
    chk("reset overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    disp_ena = 1'b1;
    pulse_tick();
    pulse_tick();
    wait_quiet("init", 3000);
    chk("init count", 32'(q.size()), 32'd5);
    for (int i = 0; i < 5; i++) chk($sformatf("init word%0d", i), 32'(q[i]), 32'(INIT_W[i]));
    chk("init_done", 32'(init_done), 32'd1);
    chk("init busy", 32'(busy), 32'd0);
    chk("init overrun", 32'(overrun), 32'd0);

    q.delete();
    digits_in = 24'h012345;
    pulse_tick();
    wait_quiet("frame1", 3000);
    chk("frame1 count", 32'(q.size()), 32'd6);
    for (int i = 0; i < 6; i++) chk($sformatf("frame1 word%0d", i), 32'(q[i]), 32'(FRM_A[i]));

    q.delete();
    pulse_tick();
    repeat (100) @(negedge clk);
    digits_in = 24'h099999;
    pulse_tick();
    chk("overrun after 2nd tick", 32'(overrun), 32'd0);
    repeat (100) @(negedge clk);
    pulse_tick();
    chk("overrun after 3rd tick", 32'(overrun), 32'd1);
    chk("busy mid frame", 32'(busy), 32'd1);
    wait_quiet("frame2", 6000);
    chk("frame2 count", 32'(q.size()), 32'd12);
    for (int i = 0; i < 6; i++) chk($sformatf("snap word%0d", i), 32'(q[i]), 32'(FRM_A[i]));
    for (int i = 0; i < 6; i++) chk($sformatf("next word%0d", i), 32'(q[i+6]), 32'(FRM_B[i]));

    q.delete();
    disp_ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pulse_tick();
      repeat (5) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    chk("disabled no spi", 32'(q.size()), 32'd0);
    chk("disabled busy", 32'(busy), 32'd0);
    a0 = ack_cnt;
    int_val = 4'h3;
    int_req = 1'b1;
    wait_ack("cfg", 1000);
    wait_quiet("cfg", 1000);
    chk("cfg ack pulses", 32'(ack_cnt - a0), 32'd1);
    chk("cfg count", 32'(q.size()), 32'd1);
    chk("cfg word", 32'(q[0]), 32'h0A03);

    q.delete();
    disp_ena = 1'b1;
    digits_in = 24'h012345;
    int_val = 4'h5;
    int_req = 1'b1;
    pulse_tick();
    wait_ack("prio", 1000);
    wait_quiet("prio", 3000);
    chk("prio count", 32'(q.size()), 32'd7);
    chk("prio cfg first", 32'(q[0]), 32'h0A05);
    for (int i = 0; i < 6; i++) chk($sformatf("prio frame word%0d", i), 32'(q[i+1]), 32'(FRM_A[i]));

    q.delete();
    pulse_tick();
    for (int n = 0; n < 1000 && q.size() < 3; n++) @(negedge clk);
    chk("third word reached", 32'(q.size()), 32'd3);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort cs", 32'(bus.spi_cs), 32'd1);
    chk("abort overrun", 32'(overrun), 32'd0);
    chk("abort init_done", 32'(init_done), 32'd0);
    chk("abort busy", 32'(busy), 32'd1);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    wait_quiet("reinit", 3000);
    chk("reinit count", 32'(q.size()), 32'd5);
    for (int i = 0; i < 5; i++) chk($sformatf("reinit word%0d", i), 32'(q[i]), 32'(INIT_W[i]));
    chk("reinit init_done", 32'(init_done), 32'd1);
    chk("word stable while cs low", 32'(stab_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
